// File: rtl/mult_rr_arbiter.sv
// Round-robin front end sharing one pipelined 32x32->64 multiplier.
// Credit-limited issue feeds an in-order result FIFO tagged by requester.
module mult_rr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int MULT_LAT   = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int IDW        = $clog2(NUM_REQ)
) (
  input  logic                  CLK,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [32*NUM_REQ-1:0] req_a,
  input  logic [32*NUM_REQ-1:0] req_b,
  output logic [31:0]           mult_a,
  output logic [31:0]           mult_b,
  input  logic [63:0]           mult_c,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [IDW-1:0]        resp_id,
  output logic [63:0]           resp_data,
  output logic                  busy
);

  localparam int PS  = MULT_LAT + 1;
  localparam int FAW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FCW = $clog2(FIFO_DEPTH + 1);
  localparam int OCW = $clog2(PS + FIFO_DEPTH + 1);

  logic [IDW-1:0] ptr;
  logic [PS-1:0]  pipe_vld;
  logic [IDW-1:0] pipe_id [PS];

  logic [63:0]    mem_data [FIFO_DEPTH];
  logic [IDW-1:0] mem_id   [FIFO_DEPTH];
  logic [FAW-1:0] wr_ptr;
  logic [FAW-1:0] rd_ptr;
  logic [FCW-1:0] fcnt;

  logic [OCW-1:0] inflight;
  logic [OCW-1:0] outstanding;
  logic           issue_ok;
  logic           gnt_vld;
  logic [IDW-1:0] gnt_id;
  logic [IDW:0]   sum;
  logic [IDW-1:0] cand;
  logic           hs;
  logic [31:0]    sel_a;
  logic [31:0]    sel_b;
  logic           push;
  logic           pop;
  logic           fifo_full;

  always_comb begin
    inflight = '0;
    for (int s = 0; s < PS; s++) begin
      inflight = inflight + OCW'(pipe_vld[s]);
    end
  end

  // A pop in this cycle does not free credit until the next one.
  assign outstanding = inflight + OCW'(fcnt);
  assign issue_ok    = outstanding < OCW'(FIFO_DEPTH);
  assign busy        = outstanding != '0;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    sum     = '0;
    cand    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      sum = {1'b0, ptr} + (IDW+1)'(k);
      if (sum >= (IDW+1)'(NUM_REQ)) begin
        sum = sum - (IDW+1)'(NUM_REQ);
      end
      cand = sum[IDW-1:0];
      if (!gnt_vld && req_valid[cand]) begin
        gnt_vld = 1'b1;
        gnt_id  = cand;
      end
    end
  end

  assign hs = gnt_vld & issue_ok;

  assign req_ready = (hs && !rst) ?
                     (NUM_REQ'(1) << gnt_id) : '0;

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_id == IDW'(i)) begin
        sel_a = req_a[32*i +: 32];
        sel_b = req_b[32*i +: 32];
      end
    end
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      ptr      <= IDW'(NUM_REQ - 1);
      mult_a   <= '0;
      mult_b   <= '0;
      pipe_vld <= '0;
      for (int s = 0; s < PS; s++) begin
        pipe_id[s] <= '0;
      end
    end else begin
      if (hs) begin
        ptr <= gnt_id;
      end
      mult_a      <= hs ? sel_a : '0;
      mult_b      <= hs ? sel_b : '0;
      pipe_vld[0] <= hs;
      pipe_id[0]  <= hs ? gnt_id : '0;
      for (int s = 1; s < PS; s++) begin
        pipe_vld[s] <= pipe_vld[s-1];
        pipe_id[s]  <= pipe_id[s-1];
      end
    end
  end

  assign push      = pipe_vld[PS-1];
  assign fifo_full = fcnt == FCW'(FIFO_DEPTH);
  assign pop       = resp_valid & resp_ready;

  function automatic logic [FAW-1:0] nxt(input logic [FAW-1:0] p);
    return (p == FAW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge CLK) begin
    if (push) begin
      mem_data[wr_ptr] <= mult_c;
      mem_id[wr_ptr]   <= pipe_id[PS-1];
    end
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fcnt   <= '0;
    end else begin
      if (push) begin
        wr_ptr <= nxt(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= nxt(rd_ptr);
      end
      unique case ({push, pop})
        2'b10:   fcnt <= fcnt + 1'b1;
        2'b01:   fcnt <= fcnt - 1'b1;
        default: fcnt <= fcnt;
      endcase
    end
  end

  assign resp_valid = fcnt != '0;
  assign resp_id    = resp_valid ? mem_id[rd_ptr] : '0;
  assign resp_data  = resp_valid ? mem_data[rd_ptr] : '0;

  a_no_overflow: assert property (
    @(posedge CLK) disable iff (rst) !(push && fifo_full)
  );

endmodule

// File: tb/tb_mult_rr_arbiter.sv
// Bench for mult_rr_arbiter: queue-based reference model, directed
// scenarios with literal expectations, then randomized traffic.
module tb_mult_rr_arbiter;

  localparam int N    = 4;
  localparam int LAT  = 1;
  localparam int FD   = 4;
  localparam int IDW  = 2;
  localparam int RLAT = LAT + 2;
  localparam int BW   = $clog2(32 * N);

  logic            CLK = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [32*N-1:0] req_a = '0;
  logic [32*N-1:0] req_b = '0;
  logic [31:0]     mult_a;
  logic [31:0]     mult_b;
  logic [63:0]     mult_c = '0;
  logic            resp_valid;
  logic            resp_ready = 1'b0;
  logic [IDW-1:0]  resp_id;
  logic [63:0]     resp_data;
  logic            busy;

  int errors = 0;
  int checks = 0;

  mult_rr_arbiter #(
    .NUM_REQ(N), .MULT_LAT(LAT), .FIFO_DEPTH(FD), .IDW(IDW)
  ) dut (
    .CLK(CLK), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .mult_a(mult_a), .mult_b(mult_b), .mult_c(mult_c),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_data(resp_data),
    .busy(busy)
  );

  always #5 CLK = ~CLK;

  // one-cycle multiplier
  always @(posedge CLK)
    mult_c <= {32'b0, mult_a} * {32'b0, mult_b};

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [63:0]    prod;
    int             acc;
  } ent_t;

  ent_t         q[$];
  int           m_ptr = N - 1;
  int           cyc = 0;
  logic [31:0]  m_ma = '0;
  logic [31:0]  m_mb = '0;
  int           e_g;
  logic [N-1:0] e_ready;
  logic         e_rv;
  logic [IDW-1:0] e_id;
  logic [63:0]  e_data;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h cyc=%0d", nm, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] op_a(input int i);
    logic [BW-1:0] b;
    b = BW'(32 * i);
    return req_a[b +: 32];
  endfunction

  function automatic logic [31:0] op_b(input int i);
    logic [BW-1:0] b;
    b = BW'(32 * i);
    return req_b[b +: 32];
  endfunction

  task automatic set_op(input int i, input logic [31:0] a,
                        input logic [31:0] b);
    logic [BW-1:0] base;
    base = BW'(32 * i);
    req_a[base +: 32] = a;
    req_b[base +: 32] = b;
  endtask

  task automatic model_eval();
    e_g = -1;
    if (q.size() < FD) begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (e_g < 0 && req_valid[IDW'(c)]) e_g = c;
      end
    end
    e_ready = (e_g >= 0) ? (N'(1) << e_g) : '0;
    e_rv    = q.size() > 0 && cyc >= q[0].acc + RLAT;
    e_id    = e_rv ? q[0].id : '0;
    e_data  = e_rv ? q[0].prod : '0;
  endtask

  task automatic model_reset();
    q.delete();
    m_ptr = N - 1;
    m_ma  = '0;
    m_mb  = '0;
  endtask

  task automatic sample();
    #1;
    model_eval();
    chk("req_ready", req_ready, e_ready);
    chk("resp_valid", resp_valid, e_rv);
    chk("resp_id", resp_id, e_id);
    chk("resp_data", resp_data, e_data);
    chk("busy", busy, q.size() != 0);
    chk("mult_a", mult_a, m_ma);
    chk("mult_b", mult_b, m_mb);
  endtask

  task automatic advance();
    ent_t e;
    @(posedge CLK);
    if (e_g >= 0) begin
      e.id   = IDW'(e_g);
      e.prod = {32'b0, op_a(e_g)} * {32'b0, op_b(e_g)};
      e.acc  = cyc;
      q.push_back(e);
      m_ptr = e_g;
      m_ma  = op_a(e_g);
      m_mb  = op_b(e_g);
    end else begin
      m_ma = '0;
      m_mb = '0;
    end
    if (e_rv && resp_ready) void'(q.pop_front());
    cyc++;
    @(negedge CLK);
  endtask

  task automatic tick();
    sample();
    advance();
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b1;
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_mult_a", mult_a, 0);
    chk("rst_mult_b", mult_b, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_id", resp_id, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_busy", busy, 0);
    model_reset();
    @(posedge CLK);
    cyc++;
    @(negedge CLK);
    rst = 1'b0;
  endtask

  initial begin
    int acc;
    @(negedge CLK);
    do_reset();

    // single op
    resp_ready = 1'b1;
    set_op(0, 32'd3, 32'd5);
    req_valid = 4'b0001;
    sample(); chk("single_accept", req_ready, 4'b0001); advance();
    req_valid = '0;
    tick(); tick();
    sample();
    chk("single_rv", resp_valid, 1);
    chk("single_id", resp_id, 0);
    chk("single_data", resp_data, 64'd15);
    advance();
    sample(); chk("single_busy_low", busy, 0); advance();

    // max operands
    set_op(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    req_valid = 4'b0100;
    sample(); chk("max_accept", req_ready, 4'b0100); advance();
    req_valid = '0;
    tick(); tick();
    sample();
    chk("max_id", resp_id, 2);
    chk("max_data", resp_data, 64'hFFFF_FFFE_0000_0001);
    advance();
    tick();

    // contention
    do_reset();
    resp_ready = 1'b1;
    for (int i = 0; i < N; i++) set_op(i, 32'(i + 1), 32'd16);
    req_valid = '1;
    for (int k = 0; k < 12; k++) begin
      sample();
      chk("cont_grant", req_ready, 4'b0001 << (k % 4));
      if (k >= 3) begin
        chk("cont_rv", resp_valid, 1);
        chk("cont_id", resp_id, 64'((k - 3) % 4));
        chk("cont_data", resp_data, 64'(16 * ((k - 3) % 4 + 1)));
      end
      advance();
    end
    req_valid = '0;
    for (int k = 0; k < 5; k++) tick();

    // backpressure
    resp_ready = 1'b0;
    req_valid  = '1;
    acc = 0;
    for (int k = 0; k < 8; k++) begin
      sample();
      if (req_ready != '0) acc++;
      advance();
    end
    chk("bp_accepts", 64'(acc), 4);
    resp_ready = 1'b1;
    sample();
    chk("bp_head_id", resp_id, 0);
    chk("bp_no_credit", req_ready, 0);
    advance();
    sample(); chk("bp_resume", req_ready, 4'b0001); advance();
    req_valid = '0;
    for (int k = 0; k < 8; k++) tick();

    // round-robin pointer
    do_reset();
    req_valid = 4'b1000;
    sample(); chk("rr_first", req_ready, 4'b1000); advance();
    req_valid = '0;
    tick(); tick(); tick();
    req_valid = 4'b0110;
    sample(); chk("rr_req1", req_ready, 4'b0010); advance();
    sample(); chk("rr_req2", req_ready, 4'b0100); advance();
    req_valid = '0;
    for (int k = 0; k < 6; k++) tick();

    // reset mid-operation
    resp_ready = 1'b0;
    req_valid  = '1;
    tick(); tick(); tick();
    req_valid = '0;
    tick(); tick();
    req_valid = '1;
    do_reset();
    req_valid = '0;
    for (int k = 0; k < 6; k++) begin
      sample(); chk("post_rst_quiet", resp_valid, 0); advance();
    end
    resp_ready = 1'b1;
    set_op(1, 32'd7, 32'd6);
    req_valid = 4'b0010;
    sample(); chk("post_rst_accept", req_ready, 4'b0010); advance();
    req_valid = '0;
    tick(); tick();
    sample();
    chk("post_rst_id", resp_id, 1);
    chk("post_rst_data", resp_data, 64'd42);
    advance();
    tick();

    // randomized traffic
    for (int k = 0; k < 600; k++) begin
      req_valid = N'($urandom_range(0, 15));
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 3) == 0)
          set_op(i, $urandom, $urandom);
        else
          set_op(i, 32'($urandom_range(0, 255)), $urandom);
      end
      if (k < 200)      resp_ready = ($urandom_range(0, 3) != 0);
      else if (k < 400) resp_ready = ($urandom_range(0, 3) == 0);
      else              resp_ready = 1'($urandom_range(0, 1));
      tick();
    end
    req_valid  = '0;
    resp_ready = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    chk("final_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
